// File: rtl/pll_seq_pkg.sv
// PLL lock sequencer shared types.
// State encoding and status field widths.
package pll_seq_pkg;

  localparam int STATE_W = 3;
  localparam int RETRY_W = 2;
  localparam int LOSS_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_PLLRST   = 3'd0,
    ST_WAITLOCK = 3'd1,
    ST_STABLE   = 3'd2,
    ST_RUN      = 3'd3,
    ST_FAIL     = 3'd4
  } state_e;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, 1 bit.
// Async active-low reset clears both stages.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/pll_lock_seq.sv
// PLL bring-up sequencer: reset hold, lock wait,
// stability window, run monitoring and retry/fail.
module pll_lock_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 16000,
  parameter int STABLE_CYCLES = 1600,
  parameter int MAX_RETRIES   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               locked,
  input  logic               restart,
  output logic               pll_resetb,
  output logic               sys_rst_n,
  output logic               fail,
  output logic [STATE_W-1:0] state,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  loss_cnt
);

  localparam int CNT_MAX =
    max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] RST_END =
    CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_END =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAB_END =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX =
    RETRY_W'(MAX_RETRIES);

  logic               lock_s;
  state_e             st, st_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [RETRY_W-1:0] retry_n;
  logic [LOSS_W-1:0]  loss_n;
  logic               do_retry;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (lock_s)
  );

  always_comb begin
    st_n     = st;
    retry_n  = retry_cnt;
    loss_n   = loss_cnt;
    do_retry = 1'b0;
    unique case (st)
      ST_PLLRST: begin
        if (cnt == RST_END) st_n = ST_WAITLOCK;
      end
      ST_WAITLOCK: begin
        if (lock_s) st_n = ST_STABLE;
        else if (cnt == LOCK_END) do_retry = 1'b1;
      end
      ST_STABLE: begin
        if (!lock_s) do_retry = 1'b1;
        else if (cnt == STAB_END) st_n = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) begin
          do_retry = 1'b1;
          if (loss_cnt != '1) loss_n = loss_cnt + 1'b1;
        end
      end
      ST_FAIL: ;
      default: st_n = ST_PLLRST;
    endcase
    if (do_retry) begin
      if (retry_cnt == RETRY_MAX) begin
        st_n = ST_FAIL;
      end else begin
        retry_n = retry_cnt + 1'b1;
        st_n    = ST_PLLRST;
      end
    end
    if (st_n == ST_RUN && st != ST_RUN) retry_n = '0;
    if (restart) begin
      st_n    = ST_PLLRST;
      retry_n = '0;
    end
    // Counter idles in RUN/FAIL so it can never wrap.
    if (restart || st_n != st) cnt_n = '0;
    else if (st == ST_RUN || st == ST_FAIL) cnt_n = cnt;
    else cnt_n = cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_PLLRST;
      cnt        <= '0;
      retry_cnt  <= '0;
      loss_cnt   <= '0;
      pll_resetb <= 1'b0;
      sys_rst_n  <= 1'b0;
      fail       <= 1'b0;
    end else begin
      st         <= st_n;
      cnt        <= cnt_n;
      retry_cnt  <= retry_n;
      loss_cnt   <= loss_n;
      pll_resetb <= !(st_n == ST_PLLRST ||
                      st_n == ST_FAIL);
      sys_rst_n  <= (st_n == ST_RUN);
      fail       <= (st_n == ST_FAIL);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq with small parameters.
// Rows: drive inputs for n cycles, then compare outputs.
module tb_pll_lock_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       restart;
  logic       pll_resetb;
  logic       sys_rst_n;
  logic       fail;
  logic [2:0] state;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_lock_seq #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .locked     (locked),
    .restart    (restart),
    .pll_resetb (pll_resetb),
    .sys_rst_n  (sys_rst_n),
    .fail       (fail),
    .state      (state),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  typedef struct {
    string      name;
    logic       lk;
    logic       rs;
    int         n;
    logic [2:0] st;
    logic       prb;
    logic       sys;
    logic       fl;
    logic [1:0] rt;
    logic [7:0] ls;
  } row_t;

  row_t tbl [14];

  task automatic check(input row_t r);
    checks++;
    if ({state, pll_resetb, sys_rst_n, fail,
         retry_cnt, loss_cnt} !==
        {r.st, r.prb, r.sys, r.fl, r.rt, r.ls}) begin
      errors++;
      $display("FAIL %s: got st=%0d prb=%b sys=%b fail=%b rt=%0d loss=%0d, want st=%0d prb=%b sys=%b fail=%b rt=%0d loss=%0d",
               r.name, state, pll_resetb, sys_rst_n,
               fail, retry_cnt, loss_cnt, r.st, r.prb,
               r.sys, r.fl, r.rt, r.ls);
    end
  endtask

  task automatic apply(input row_t r);
    locked  = r.lk;
    restart = r.rs;
    repeat (r.n) @(posedge clk);
    #1;
    check(r);
  endtask

  task automatic run(
    input string      name,
    input logic       lk,
    input logic       rs,
    input int         n,
    input logic [2:0] st,
    input logic       prb,
    input logic       sys,
    input logic       fl,
    input logic [1:0] rt,
    input logic [7:0] ls
  );
    row_t r;
    r = '{name, lk, rs, n, st, prb, sys, fl, rt, ls};
    apply(r);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    locked  = 1'b0;
    restart = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    // Normal bring-up, then lock loss in RUN and relock.
    tbl[0]  = '{"hold",      0, 0, 3, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{"release",   0, 0, 1, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{"wait",      0, 0, 3, 1, 1, 0, 0, 0, 0};
    tbl[3]  = '{"sync_lat",  1, 0, 2, 1, 1, 0, 0, 0, 0};
    tbl[4]  = '{"stable_in", 1, 0, 1, 2, 1, 0, 0, 0, 0};
    tbl[5]  = '{"stable_7",  1, 0, 7, 2, 1, 0, 0, 0, 0};
    tbl[6]  = '{"run_in",    1, 0, 1, 3, 1, 1, 0, 0, 0};
    tbl[7]  = '{"run_hold",  1, 0, 5, 3, 1, 1, 0, 0, 0};
    tbl[8]  = '{"loss_lat",  0, 0, 2, 3, 1, 1, 0, 0, 0};
    tbl[9]  = '{"loss",      0, 0, 1, 0, 0, 0, 0, 1, 1};
    tbl[10] = '{"re_hold",   0, 0, 3, 0, 0, 0, 0, 1, 1};
    tbl[11] = '{"re_wait",   0, 0, 1, 1, 1, 0, 0, 1, 1};
    tbl[12] = '{"re_stable", 1, 0, 3, 2, 1, 0, 0, 1, 1};
    tbl[13] = '{"re_run",    1, 0, 8, 3, 1, 1, 0, 0, 1};

    rst_n   = 1'b0;
    locked  = 1'b0;
    restart = 1'b0;
    #2;
    run("por", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) apply(tbl[i]);

    // Async reset mid-RUN, off the clock edge.
    #3;
    rst_n = 1'b0;
    run("async_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    run("ar_hold",   1, 0, 3, 0, 0, 0, 0, 0, 0);
    run("ar_wait",   1, 0, 1, 1, 1, 0, 0, 0, 0);
    run("ar_stable", 1, 0, 1, 2, 1, 0, 0, 0, 0);
    run("ar_run",    1, 0, 8, 3, 1, 1, 0, 0, 0);

    // One-cycle lock glitch inside STABLE.
    do_reset();
    run("g_wait",    0, 0, 4, 1, 1, 0, 0, 0, 0);
    run("g_stable",  1, 0, 3, 2, 1, 0, 0, 0, 0);
    run("g_stab2",   1, 0, 2, 2, 1, 0, 0, 0, 0);
    run("g_drop",    0, 0, 1, 2, 1, 0, 0, 0, 0);
    run("g_lat",     1, 0, 1, 2, 1, 0, 0, 0, 0);
    run("g_retry",   1, 0, 1, 0, 0, 0, 0, 1, 0);

    // Repeated timeouts down to FAIL, restart out of FAIL.
    do_reset();
    run("t_wait0",   0, 0, 4, 1, 1, 0, 0, 0, 0);
    run("t_edge0",   0, 0, 19, 1, 1, 0, 0, 0, 0);
    run("t_to0",     0, 0, 1, 0, 0, 0, 0, 1, 0);
    run("t_wait1",   0, 0, 4, 1, 1, 0, 0, 1, 0);
    run("t_to1",     0, 0, 20, 0, 0, 0, 0, 2, 0);
    run("t_wait2",   0, 0, 4, 1, 1, 0, 0, 2, 0);
    run("t_fail",    0, 0, 20, 4, 0, 0, 1, 2, 0);
    run("t_fail_hd", 0, 0, 10, 4, 0, 0, 1, 2, 0);
    run("r_fail",    0, 1, 1, 0, 0, 0, 0, 0, 0);
    run("r_wait",    0, 0, 4, 1, 1, 0, 0, 0, 0);

    // Restart on the same edge as a timeout.
    run("rt_to",     0, 0, 20, 0, 0, 0, 0, 1, 0);
    run("rt_wait",   0, 0, 4, 1, 1, 0, 0, 1, 0);
    run("rt_edge",   0, 0, 19, 1, 1, 0, 0, 1, 0);
    run("rt_both",   0, 1, 1, 0, 0, 0, 0, 0, 0);
    run("rt_hold",   0, 0, 3, 0, 0, 0, 0, 0, 0);
    run("rt_rel",    0, 0, 1, 1, 1, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_seq.md
PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

Interface
REQ-001 Parameter RST_CYCLES, 16, cycles the PLL RESETB is held low per attempt (>=2).
REQ-002 Parameter LOCK_TIMEOUT, 16000, cycles allowed for lock after RESETB release (1 ms at 16 MHz).
REQ-003 Parameter STABLE_CYCLES, 1600, cycles lock must stay high before system reset release.
REQ-004 Parameter MAX_RETRIES, 3, failed attempts tolerated before FAIL.
REQ-005 clk  input  1  free-running reference clock, the same clock feeding the PLL REFERENCECLK; single clock domain.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 locked  input  1  PLL LOCK output, asynchronous to clk.
REQ-008 restart  input  1  one-cycle pulse, restarts the sequence and clears the retry budget.
REQ-009 pll_resetb  output  1  drives PLL RESETB; low holds the PLL in reset.
REQ-010 sys_rst_n  output  1  active-low reset for logic clocked by the PLL output.
REQ-011 fail  output  1  high while in FAIL.
REQ-012 state  output  3  current state encoding, for status registers.
REQ-013 retry_cnt  output  2  attempts consumed in the current bring-up.
REQ-014 loss_cnt  output  8  saturating count of lock losses while in RUN.

Function
REQ-015 locked SHALL pass through a 2-flop synchronizer to give lock_s; all decisions use lock_s only (2-cycle latency).
REQ-016 States: PLLRST, WAITLOCK, STABLE, RUN, FAIL; one shared counter cnt, cleared on every state change.
REQ-017 PLLRST: pll_resetb=0, sys_rst_n=0; at cnt==RST_CYCLES-1 go to WAITLOCK.
REQ-018 WAITLOCK: pll_resetb=1; lock_s=1 -> STABLE; else at cnt==LOCK_TIMEOUT-1 -> RETRY action.
REQ-019 STABLE: lock_s=0 -> RETRY action; lock_s=1 at cnt==STABLE_CYCLES-1 -> RUN.
REQ-020 RUN: sys_rst_n=1; lock_s=0 -> loss_cnt+1 (saturating at 255), then RETRY action; sys_rst_n low on the same edge.
REQ-021 RETRY action: retry_cnt==MAX_RETRIES -> FAIL; else retry_cnt+1, go to PLLRST.
REQ-022 Entering RUN SHALL clear retry_cnt to 0.
REQ-023 FAIL: pll_resetb=0, sys_rst_n=0, fail=1; leaves only on restart.
REQ-024 restart in any state -> PLLRST, retry_cnt=0, fail=0; restart wins over any simultaneous timeout, lock loss or completion.
REQ-025 All outputs SHALL be registered; sys_rst_n SHALL never be high unless state==RUN and pll_resetb==1.
REQ-026 cnt width SHALL be sized by clog2 of the largest of RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES; no wrap is reachable.

Reset
REQ-027 rst_n low SHALL asynchronously force: state=PLLRST, cnt=0, pll_resetb=0, sys_rst_n=0, fail=0, retry_cnt=0, loss_cnt=0, synchronizer flops=0.
REQ-028 rst_n deassertion mid-operation SHALL always restart at PLLRST with a full RST_CYCLES hold.

Structure
REQ-029 Package pll_seq_pkg SHALL hold the state enum and its 3-bit encoding (PLLRST=0, WAITLOCK=1, STABLE=2, RUN=3, FAIL=4) and the status field widths.
REQ-030 Sub-module sync_2ff (1-bit, async active-low reset) SHALL implement the locked synchronizer.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-031 Normal: rst_n released, locked high 3 cycles after pll_resetb rises -> pll_resetb high after 4 cycles, sys_rst_n high 8 cycles after lock_s, retry_cnt=0.
REQ-032 Timeout: locked held 0 -> three WAITLOCK windows of 20 cycles, retry_cnt 1 then 2, then FAIL with fail=1 and pll_resetb=0.
REQ-033 Glitch: locked drops for 1 cycle during STABLE -> PLLRST, retry_cnt=1, sys_rst_n stays 0.
REQ-034 Run loss: locked drops in RUN -> sys_rst_n low within 3 cycles, loss_cnt=1, relock -> RUN again with retry_cnt=0.
REQ-035 Restart: restart pulse in FAIL, and restart on the same cycle as a WAITLOCK timeout -> PLLRST, retry_cnt=0, fail=0.
REQ-036 Async reset: rst_n pulsed low mid-RUN, not aligned to clk -> all outputs at reset values immediately, full sequence repeats.
